// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types and constants for the data-memory access sequencer
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;
  localparam logic [1:0]  WORD_ALIGN_MASK        = 2'b11;

  // A word access must have both low address bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - BUSY-cycle watchdog, present only when MEM_TIMEOUT_EN is defined
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Count un-acknowledged BUSY cycles; restart whenever the sequencer is not BUSY.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged during the LIMIT-th un-acknowledged cycle, so an ack in that cycle wins.
  assign expired_o = enable_i && (cnt_q == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - EX/MEM data-memory request sequencer with pipeline stall; optional watchdog via MEM_TIMEOUT_EN
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        misalign_err,
  output logic        timeout_err
);

  state_e      state_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
  logic        rdata_valid_q, misalign_q, timeout_q;
  logic        access;
  logic        tmo_expired;

  assign access = memread_in | memwrite_in;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (state_q != BUSY),
    .enable_i ((state_q == BUSY) && !mem_ack),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Sequencer FSM; all memory-side and completion outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (is_misaligned(addr_in)) begin
              rdata_q       <= '0;
              rdata_valid_q <= 1'b1;
              misalign_q    <= 1'b1;
              state_q       <= DONE;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= memwrite_in;
              mem_addr_q  <= addr_in;
              mem_wdata_q <= wdata_in;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req_q     <= 1'b0;
            rdata_valid_q <= 1'b1;
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            state_q <= DONE;
          end else if (tmo_expired) begin
            mem_req_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b1;
            timeout_q     <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Freeze upstream while an access is being picked up or is in flight; DONE lets the pipe advance.
  assign stall = ((state_q == IDLE) && access) || (state_q == BUSY);

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rdata_out    = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memread_in, memwrite_in;
  logic [31:0] addr_in, wdata_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid, misalign_err, timeout_err;

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
`else
  mem_access_ctrl dut (
`endif
    .clk         (clk),
    .reset_n     (reset_n),
    .memread_in  (memread_in),
    .memwrite_in (memwrite_in),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata;
  int          total = 0;
  int          bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered just after a posedge with the DUT in IDLE; returns just after the posedge ending DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int waits, input bit ack_en,
                            input logic [31:0] rdat);
    exp_t e;
    exp_t x;
    int   exp_stall, exp_req;
    int   stalls = 0;
    int   reqs   = 0;
    bit   done   = 0;
    bit   is_wr  = wr;
    if (a[1:0] != 2'b00) begin
      e.rdata = 32'h0; e.mis = 1'b1; e.tmo = 1'b0;
      exp_stall = 1; exp_req = 0;
    end else if (!ack_en) begin
      e.rdata = 32'h0; e.mis = 1'b0; e.tmo = 1'b1;
      exp_stall = TMO + 1; exp_req = TMO;
    end else begin
      e.rdata = is_wr ? model_rdata : rdat; e.mis = 1'b0; e.tmo = 1'b0;
      exp_stall = waits + 2; exp_req = waits + 1;
    end
    model_rdata = e.rdata;
    sb_q.push_back(e);
    memread_in = rd; memwrite_in = wr; addr_in = a; wdata_in = wd;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (stall) stalls++;
      if (mem_req) begin
        reqs++;
        check_eq("mem_addr", mem_addr, a);
        check_eq("mem_we", {31'h0, mem_we}, {31'h0, wr});
        if (wr) check_eq("mem_wdata", mem_wdata, wd);
        if (ack_en && reqs == waits + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = rdat;
        end
      end
      if (rdata_valid) begin
        done = 1;
        check_eq("done_stall", {31'h0, stall}, 32'h0);
        check_eq("done_req", {31'h0, mem_req}, 32'h0);
        check_eq("sb_size", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          x = sb_q.pop_front();
          check_eq("rdata_out", rdata_out, x.rdata);
          check_eq("misalign_err", {31'h0, misalign_err}, {31'h0, x.mis});
          check_eq("timeout_err", {31'h0, timeout_err}, {31'h0, x.tmo});
        end
      end
      @(posedge clk); #1;
    end
    memread_in = 1'b0; memwrite_in = 1'b0; mem_ack = 1'b0;
    check_eq("done_seen", {31'h0, done}, 32'h1);
    check_eq("stall_cycles", stalls, exp_stall);
    check_eq("req_cycles", reqs, exp_req);
  endtask

  initial begin
    reset_n = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
    addr_in = '0; wdata_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_rdata", rdata_out, 32'h0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_flags", {29'h0, rdata_valid, misalign_err, timeout_err}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait load, 3-wait store, misaligned load
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 1, 32'hDEADBEEF);
    run_access(1'b0, 1'b1, 32'h80, 32'h12345678, 3, 1, 32'h55AA55AA);
    run_access(1'b1, 1'b0, 32'h42, 32'h0, 0, 1, 32'h11111111);
    // both controls high behaves as a write
    run_access(1'b1, 1'b1, 32'h84, 32'hA5A5A5A5, 1, 1, 32'h22222222);
    // back-to-back loads
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 1, 32'h01010101);
    run_access(1'b1, 1'b0, 32'h14, 32'h0, 2, 1, 32'h02020202);
`ifdef MEM_TIMEOUT_EN
    run_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 0, 32'h0);
    run_access(1'b1, 1'b0, 32'h204, 32'h0, TMO - 1, 1, 32'hCAFEF00D);
`else
    run_access(1'b1, 1'b0, 32'h300, 32'h0, 6, 1, 32'hCAFEF00D);
`endif

    // reset in the middle of a pending read
    memread_in = 1'b1; addr_in = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_req", {31'h0, mem_req}, 32'h1);
    check_eq("mid_addr", mem_addr, 32'h100);
    reset_n = 1'b0;
    #1;
    check_eq("mrst_req", {31'h0, mem_req}, 32'h0);
    check_eq("mrst_stall_acc", {31'h0, stall}, 32'h1);
    check_eq("mrst_rdata", rdata_out, 32'h0);
    check_eq("mrst_addr", mem_addr, 32'h0);
    check_eq("mrst_flags", {29'h0, rdata_valid, misalign_err, timeout_err}, 32'h0);
    memread_in = 1'b0;
    #1;
    check_eq("mrst_stall_idle", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_ack_req", {31'h0, mem_req}, 32'h0);
      check_eq("late_ack_valid", {31'h0, rdata_valid}, 32'h0);
      check_eq("late_ack_rdata", rdata_out, 32'h0);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    model_rdata = 32'h0;

    // a fresh access after reset still works
    run_access(1'b1, 1'b0, 32'h8, 32'h0, 0, 1, 32'h76543210);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory access issued from the EX/MEM pipeline register. Watches the registered memread/memwrite controls and the address/store data, drives a request/acknowledge port to a variable-latency data memory, and asserts a global stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes. Sits between the EX/MEM register outputs and the MEM/WB register inputs.

## Interface
- TIMEOUT_CYCLES, 16: BUSY cycles without mem_ack before the access is abandoned (only with timeout feature).
- clk  in  1  clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- memread_in  in  1  EX/MEM memread_out.
- memwrite_in  in  1  EX/MEM memwrite_out.
- addr_in  in  32  EX/MEM alu_result_out (byte address).
- wdata_in  in  32  EX/MEM read_data2_out.
- mem_req  out  1  request to data memory, registered.
- mem_we  out  1  1 = write, valid with mem_req.
- mem_addr  out  32  latched address, valid with mem_req.
- mem_wdata  out  32  latched store data, valid with mem_req.
- mem_ack  in  1  memory completion; sampled only in BUSY.
- mem_rdata  in  32  load data, valid with mem_ack.
- stall  out  1  freeze upstream pipeline registers.
- rdata_out  out  32  load data to MEM/WB, held until next completion.
- rdata_valid  out  1  one-cycle pulse in DONE.
- misalign_err  out  1  one-cycle pulse in DONE for misaligned access.
- timeout_err  out  1  one-cycle pulse in DONE for timed-out access.

## Operation
- States: IDLE, BUSY, DONE.
- access = memread_in | memwrite_in. Both high is treated as a write.
- IDLE: stall = access (combinational). On access with addr_in[1:0]==0: latch addr/wdata/we, go BUSY. On access with addr_in[1:0]!=0: issue nothing, rdata_out <= 0, go DONE with misalign flag. No access: stay.
- BUSY: mem_req=1, stall=1. On mem_ack: rdata_out <= mem_rdata for reads (unchanged for writes), go DONE.
- DONE: stall=0, mem_req=0, rdata_valid=1, error pulses as flagged; the pipeline advances at the end of this cycle. Next state IDLE unconditionally. The access visible in DONE is the completed one and is never re-issued.
- mem_ack outside BUSY is ignored.
- Reset (any state, including mid-BUSY): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, rdata_valid=0, both error outputs 0. stall then follows IDLE rule. An in-flight memory transaction is abandoned; a late mem_ack is ignored.

## Timing
- Zero-wait memory (ack in first BUSY cycle): access at cycle 0 -> BUSY cycle 1 -> DONE cycle 2; stall high cycles 0-1; 3 cycles per access.
- Memory with N wait cycles: stall high N+2 cycles, DONE follows the ack cycle.
- Misaligned: stall high cycle 0 only, DONE cycle 1.
- Back-to-back accesses: IDLE sees the next instruction the cycle after DONE; a minimum of one non-stalled cycle between accesses.
- mem_addr/mem_wdata/mem_we stable for the entire BUSY interval.

## Configuration
- MEM_TIMEOUT_EN defined: counter clears on entering BUSY, increments each BUSY cycle without ack; at TIMEOUT_CYCLES without ack, drop mem_req, rdata_out <= 0, go DONE with timeout_err pulse. Ack on the same cycle as expiry wins (normal completion).
- Undefined: no counter; BUSY waits indefinitely; timeout_err tied 0.

## Structure
- Shared package: state enum (IDLE/BUSY/DONE), default TIMEOUT_CYCLES constant, word-alignment mask constant.
- One sub-module under MEM_TIMEOUT_EN: mem_timeout_ctr (clear, enable, expired output). Everything else in a single module.

## Test plan
- Reset mid-BUSY: read to 0x100 pending, deassert reset_n -> mem_req=0, stall follows access, late ack ignored, outputs all 0.
- Zero-wait load: memread_in=1, addr 0x40, ack in first BUSY cycle with rdata 0xDEADBEEF -> stall 2 cycles, rdata_out=0xDEADBEEF, rdata_valid pulse in cycle 2.
- 3-wait store: memwrite_in=1, addr 0x80, wdata 0x12345678 -> mem_we=1, mem_addr/mem_wdata stable 4 BUSY cycles, stall 5 cycles, rdata_out unchanged.
- Misaligned load addr 0x42 -> no mem_req, stall 1 cycle, misalign_err pulse, rdata_out=0.
- Timeout (macro defined, TIMEOUT_CYCLES=4): no ack -> mem_req drops after 4 BUSY cycles, timeout_err pulse, rdata_out=0; ack coinciding with expiry -> normal completion, no error.
- Back-to-back loads 0x10 then 0x14 -> two separate requests, one non-stalled DONE cycle between, no duplicate issue of 0x10.
